// File: rtl/trf_wr_collect.sv
// Purpose : collects per-functional-unit register-file writes into per-bank queues and issues bank write strobes.
// Latency : request accepted in cycle T reaches bk_wen in T+2 (empty queue, no stall); one write per bank per cycle.
// Backpres: req_ready only for the round-robin winner of a non-full bank queue; bk_stall holds a bank's queue head.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          per-requester handshake, transfer when both high
//   req_waddr                    {row, bank}, bank in the low BW bits
//   req_bgrpid/tmask/strb/wdata  write payload per requester
//   bk_stall                     per-bank read-port priority, blocks dequeue
//   bk_wen, bk_waddr..bk_wdata   registered bank write strobe and payload
//   bk_cnt                       per-bank queue occupancy
//   err_oor                      one-cycle pulse after an accepted row >= BNK_DPTH
module trf_wr_collect #(
    parameter int PU_N     = 7,
    parameter int BANK_N   = 4,
    parameter int THDB_N   = 4,
    parameter int THD_DW   = 32,
    parameter int BNK_DPTH = 136,
    parameter int FIFO_D   = 4,
    localparam int BW = $clog2(BANK_N),
    localparam int SW = THD_DW / 8,
    localparam int AW = $clog2(BNK_DPTH),
    localparam int CW = $clog2(FIFO_D + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [PU_N-1:0]                        req_valid,
    output logic [PU_N-1:0]                        req_ready,
    input  logic [PU_N-1:0][AW+BW-1:0]             req_waddr,
    input  logic [PU_N-1:0]                        req_bgrpid,
    input  logic [PU_N-1:0][THDB_N-1:0]            req_tmask,
    input  logic [PU_N-1:0][THDB_N*SW-1:0]         req_strb,
    input  logic [PU_N-1:0][THDB_N*THD_DW-1:0]     req_wdata,
    input  logic [BANK_N-1:0]                      bk_stall,
    output logic [BANK_N-1:0]                      bk_wen,
    output logic [BANK_N-1:0][AW-1:0]              bk_waddr,
    output logic [BANK_N-1:0]                      bk_bgrpid,
    output logic [BANK_N-1:0][THDB_N-1:0]          bk_tmask,
    output logic [BANK_N-1:0][THDB_N*SW-1:0]       bk_strb,
    output logic [BANK_N-1:0][THDB_N*THD_DW-1:0]   bk_wdata,
    output logic [BANK_N-1:0][CW-1:0]              bk_cnt,
    output logic                                   err_oor
);

    localparam int PW  = (PU_N > 1) ? $clog2(PU_N) : 1;
    localparam int QW  = $clog2(FIFO_D);
    localparam int SBW = THDB_N * SW;
    localparam int DBW = THDB_N * THD_DW;

    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_D);
    localparam logic [QW-1:0] PTR_LAST = QW'(FIFO_D - 1);
    localparam logic [PW-1:0] PU_LAST  = PW'(PU_N - 1);
    localparam logic [AW:0]   ROW_LIM  = (AW + 1)'(BNK_DPTH);

    typedef struct packed {
        logic [AW-1:0]  row;
        logic           bgrpid;
        logic [THDB_N-1:0] tmask;
        logic [SBW-1:0] strb;
        logic [DBW-1:0] wdata;
    } wr_ent_t;

    wr_ent_t                  mem [BANK_N][FIFO_D];
    logic [BANK_N-1:0][QW-1:0] wr_ptr, rd_ptr;
    logic [BANK_N-1:0][CW-1:0] cnt;
    logic [BANK_N-1:0][PW-1:0] rr_ptr;

    logic [PU_N-1:0][SBW-1:0] strb_m;
    logic [PU_N-1:0]          row_ok;
    logic [PU_N-1:0]          has_data;

    logic [BANK_N-1:0]         gnt_vld;
    logic [BANK_N-1:0][PW-1:0] gnt_idx;
    logic [BANK_N-1:0]         enq, deq;
    wr_ent_t [BANK_N-1:0]      enq_dat;
    logic                      oor_any;

    assign bk_cnt = cnt;

    // Strobes of disabled threads are cleared so an all-masked write is recognisable as empty.
    always_comb begin
        strb_m   = '0;
        row_ok   = '0;
        has_data = '0;
        for (int p = 0; p < PU_N; p++) begin
            for (int t = 0; t < THDB_N; t++)
                strb_m[p][t*SW +: SW] = req_strb[p][t*SW +: SW] & {SW{req_tmask[p][t]}};
            row_ok[p]   = {1'b0, req_waddr[p][AW+BW-1:BW]} < ROW_LIM;
            has_data[p] = |strb_m[p];
        end
    end

    // Per-bank round robin: scan requesters starting at the bank's pointer. Fullness uses the
    // occupancy at the start of the cycle, so a same-cycle dequeue never opens a slot.
    always_comb begin : arb
        int idx;
        idx     = 0;
        gnt_vld = '0;
        gnt_idx = '0;
        for (int b = 0; b < BANK_N; b++) begin
            for (int o = 0; o < PU_N; o++) begin
                idx = int'(rr_ptr[b]) + o;
                if (idx >= PU_N) idx = idx - PU_N;
                if (!rst && !gnt_vld[b] && (cnt[b] < CNT_FULL) && req_valid[idx] &&
                    (req_waddr[idx][BW-1:0] == BW'(b))) begin
                    gnt_vld[b] = 1'b1;
                    gnt_idx[b] = PW'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int b = 0; b < BANK_N; b++)
            for (int p = 0; p < PU_N; p++)
                if (gnt_vld[b] && (gnt_idx[b] == PW'(p)))
                    req_ready[p] = 1'b1;
    end

    // Out-of-range and data-less writes are still accepted but never occupy a queue slot.
    always_comb begin
        enq     = '0;
        deq     = '0;
        enq_dat = '0;
        oor_any = 1'b0;
        for (int b = 0; b < BANK_N; b++) begin
            if (gnt_vld[b]) begin
                enq[b]            = row_ok[gnt_idx[b]] && has_data[gnt_idx[b]];
                oor_any           = oor_any | !row_ok[gnt_idx[b]];
                enq_dat[b].row    = req_waddr[gnt_idx[b]][AW+BW-1:BW];
                enq_dat[b].bgrpid = req_bgrpid[gnt_idx[b]];
                enq_dat[b].tmask  = req_tmask[gnt_idx[b]];
                enq_dat[b].strb   = strb_m[gnt_idx[b]];
                enq_dat[b].wdata  = req_wdata[gnt_idx[b]];
            end
            deq[b] = (cnt[b] != '0) && !bk_stall[b];
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BANK_N; b++)
            if (enq[b])
                mem[b][wr_ptr[b]] <= enq_dat[b];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rr_ptr    <= '0;
            bk_wen    <= '0;
            bk_waddr  <= '0;
            bk_bgrpid <= '0;
            bk_tmask  <= '0;
            bk_strb   <= '0;
            bk_wdata  <= '0;
            err_oor   <= 1'b0;
        end else begin
            err_oor <= oor_any;
            bk_wen  <= deq;
            for (int b = 0; b < BANK_N; b++) begin
                if (deq[b]) begin
                    bk_waddr[b]  <= mem[b][rd_ptr[b]].row;
                    bk_bgrpid[b] <= mem[b][rd_ptr[b]].bgrpid;
                    bk_tmask[b]  <= mem[b][rd_ptr[b]].tmask;
                    bk_strb[b]   <= mem[b][rd_ptr[b]].strb;
                    bk_wdata[b]  <= mem[b][rd_ptr[b]].wdata;
                    rd_ptr[b]    <= (rd_ptr[b] == PTR_LAST) ? '0 : rd_ptr[b] + 1'b1;
                end
                if (enq[b])
                    wr_ptr[b] <= (wr_ptr[b] == PTR_LAST) ? '0 : wr_ptr[b] + 1'b1;
                if (enq[b] && !deq[b])
                    cnt[b] <= cnt[b] + 1'b1;
                else if (!enq[b] && deq[b])
                    cnt[b] <= cnt[b] - 1'b1;
                if (gnt_vld[b])
                    rr_ptr[b] <= (gnt_idx[b] == PU_LAST) ? '0 : gnt_idx[b] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trf_wr_collect.sv
// Purpose : exercises trf_wr_collect at default parameters against a queue-based reference model.
// Latency : inputs change 1 time unit after a rising edge, outputs are sampled on the falling edge.
// Backpres: stimulus holds a request until the model predicts its acceptance where order matters.
module tb_trf_wr_collect;

    localparam int PU_N = 7, BANK_N = 4, FIFO_D = 4, BNK_DPTH = 136;

    typedef struct packed {
        logic [7:0]   row;
        logic         bg;
        logic [3:0]   tm;
        logic [15:0]  st;
        logic [127:0] wd;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic [6:0]         req_valid, req_ready;
    logic [6:0][9:0]    req_waddr;
    logic [6:0]         req_bgrpid;
    logic [6:0][3:0]    req_tmask;
    logic [6:0][15:0]   req_strb;
    logic [6:0][127:0]  req_wdata;
    logic [3:0]         bk_stall, bk_wen;
    logic [3:0][7:0]    bk_waddr;
    logic [3:0]         bk_bgrpid;
    logic [3:0][3:0]    bk_tmask;
    logic [3:0][15:0]   bk_strb;
    logic [3:0][127:0]  bk_wdata;
    logic [3:0][2:0]    bk_cnt;
    logic               err_oor;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    ent_t       mq [BANK_N][$];
    ent_t       exp_out [BANK_N];
    logic [3:0] exp_wen;
    logic       exp_err;
    logic [6:0] exp_ready;
    int         rr [BANK_N];
    int         gnt [BANK_N];

    trf_wr_collect dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_waddr(req_waddr),
        .req_bgrpid(req_bgrpid), .req_tmask(req_tmask), .req_strb(req_strb),
        .req_wdata(req_wdata), .bk_stall(bk_stall), .bk_wen(bk_wen),
        .bk_waddr(bk_waddr), .bk_bgrpid(bk_bgrpid), .bk_tmask(bk_tmask),
        .bk_strb(bk_strb), .bk_wdata(bk_wdata), .bk_cnt(bk_cnt), .err_oor(err_oor)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Falling edge: predict which requester each bank grants from the model state.
    task automatic sample();
        @(negedge clk);
        exp_ready = '0;
        for (int b = 0; b < BANK_N; b++) begin
            gnt[b] = -1;
            if (!rst && mq[b].size() < FIFO_D) begin
                for (int o = 0; o < PU_N; o++) begin
                    int i;
                    i = (rr[b] + o) % PU_N;
                    if (gnt[b] < 0 && req_valid[i] && int'(req_waddr[i][1:0]) == b) gnt[b] = i;
                end
            end
            if (gnt[b] >= 0) exp_ready[gnt[b]] = 1'b1;
        end
    endtask

    // Apply the cycle's effects to the model, then cross the rising edge.
    task automatic advance();
        ent_t e;
        logic nerr;
        int   p;
        if (rst) begin
            for (int b = 0; b < BANK_N; b++) begin
                mq[b].delete();
                rr[b] = 0;
                exp_out[b] = '0;
            end
            exp_wen = '0;
            exp_err = 1'b0;
        end else begin
            nerr = 1'b0;
            for (int b = 0; b < BANK_N; b++) begin
                exp_wen[b] = (mq[b].size() > 0) && !bk_stall[b];
                if (exp_wen[b]) exp_out[b] = mq[b].pop_front();
            end
            for (int b = 0; b < BANK_N; b++) begin
                if (gnt[b] >= 0) begin
                    p = gnt[b];
                    rr[b] = (p + 1) % PU_N;
                    if (int'(req_waddr[p][9:2]) >= BNK_DPTH) nerr = 1'b1;
                    else begin
                        e.row = req_waddr[p][9:2];
                        e.bg  = req_bgrpid[p];
                        e.tm  = req_tmask[p];
                        for (int t = 0; t < 4; t++) e.st[t*4 +: 4] = req_strb[p][t*4 +: 4] & {4{req_tmask[p][t]}};
                        e.wd  = req_wdata[p];
                        if (e.st != '0) mq[b].push_back(e);
                    end
                end
            end
            exp_err = nerr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        bk_stall  = '0;
    endtask

    task automatic set_req(input int p, input int bank, input int row, input logic [3:0] tm, input logic [15:0] st);
        req_valid[p]  = 1'b1;
        req_waddr[p]  = {8'(row), 2'(bank)};
        req_bgrpid[p] = 1'($urandom);
        req_tmask[p]  = tm;
        req_strb[p]   = st;
        req_wdata[p]  = rnd128();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        sample();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 7'h7F;
        sample();
        n_chk++; if (req_ready !== 7'h00) begin n_fail++; $display("FAIL reset_ready got=%b want=0", req_ready); end
        advance();
        sample();
        n_chk++; if (bk_wen !== 4'h0) begin n_fail++; $display("FAIL reset_wen got=%b want=0", bk_wen); end
        n_chk++; if (bk_cnt !== 12'h0) begin n_fail++; $display("FAIL reset_cnt got=%h want=0", bk_cnt); end
        n_chk++; if (err_oor !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", err_oor); end
        n_chk++;
        if (bk_waddr !== '0 || bk_wdata !== '0 || bk_strb !== '0 || bk_tmask !== '0 || bk_bgrpid !== '0) begin
            n_fail++; $display("FAIL reset_payload got waddr=%h strb=%h want all zero", bk_waddr, bk_strb);
        end
        advance();
        rst = 1'b0;
        idle();
    endtask

    task automatic test_single_write();
        logic [15:0]  s;
        logic [127:0] d;
        do_reset();
        s = 16'($urandom_range(1, 16'hFFFF));
        set_req(2, 1, 7, 4'hF, s);
        req_waddr[2] = 10'h01D;
        d = req_wdata[2];
        sample();
        n_chk++; if (req_ready !== 7'b0000100) begin n_fail++; $display("FAIL single_ready got=%b want=0000100", req_ready); end
        advance();
        idle();
        sample();
        n_chk++; if (bk_wen !== 4'b0000) begin n_fail++; $display("FAIL single_wen_t1 got=%b want=0000", bk_wen); end
        advance();
        sample();
        n_chk++; if (bk_wen !== 4'b0010) begin n_fail++; $display("FAIL single_wen_t2 got=%b want=0010", bk_wen); end
        n_chk++; if (bk_waddr[1] !== 8'd7) begin n_fail++; $display("FAIL single_waddr got=%0d want=7", bk_waddr[1]); end
        n_chk++; if (bk_wdata[1] !== d || bk_strb[1] !== s) begin
            n_fail++; $display("FAIL single_data got=%h/%h want=%h/%h", bk_wdata[1], bk_strb[1], d, s);
        end
        advance();
        sample();
        n_chk++; if (bk_wen !== 4'b0000) begin n_fail++; $display("FAIL single_wen_t3 got=%b want=0000", bk_wen); end
        advance();
    endtask

    task automatic test_contention();
        int seq[3] = '{0, 3, 5};
        logic [127:0] sent[$];
        logic [6:0] want;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < 3; j++) set_req(seq[j], 0, $urandom_range(0, 135), 4'hF, 16'hFFFF);
            sent.push_back(req_wdata[seq[k % 3]]);
            sample();
            want = '0;
            want[seq[k % 3]] = 1'b1;
            n_chk++; if (req_ready !== want) begin n_fail++; $display("FAIL cont_ready cyc=%0d got=%b want=%b", k, req_ready, want); end
            n_chk++; if (bk_wen[0] !== (k >= 2)) begin n_fail++; $display("FAIL cont_wen cyc=%0d got=%b want=%b", k, bk_wen[0], k >= 2); end
            if (k >= 2) begin
                n_chk++; if (bk_wdata[0] !== sent[k-2]) begin n_fail++; $display("FAIL cont_data cyc=%0d got=%h want=%h", k, bk_wdata[0], sent[k-2]); end
            end
            advance();
        end
        idle();
    endtask

    task automatic test_backpressure();
        logic [127:0] d[5];
        int idx = 0;
        int nw = 0;
        logic acc;
        do_reset();
        for (int i = 0; i < 5; i++) d[i] = rnd128();
        for (int cyc = 0; cyc < 16; cyc++) begin
            bk_stall = (cyc < 7) ? 4'b0100 : 4'b0000;
            req_valid = '0;
            if (idx < 5) begin
                set_req(1, 2, 40, 4'hF, 16'hFFFF);
                req_wdata[1] = d[idx];
            end
            acc = (cyc < 4) || (cyc == 8);
            sample();
            n_chk++; if (req_ready[1] !== acc) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%b want=%b", cyc, req_ready[1], acc); end
            if (cyc == 6) begin
                n_chk++; if (bk_cnt[2] !== 3'd4) begin n_fail++; $display("FAIL bp_cnt_full got=%0d want=4", bk_cnt[2]); end
            end
            if (bk_wen[2]) begin
                n_chk++;
                if (nw >= 5 || bk_wdata[2] !== d[nw]) begin
                    n_fail++; $display("FAIL bp_order write=%0d got=%h", nw, bk_wdata[2]);
                end
                nw++;
            end
            advance();
            if (acc) idx++;
        end
        n_chk++; if (nw !== 5) begin n_fail++; $display("FAIL bp_count got=%0d want=5", nw); end
        idle();
    endtask

    task automatic test_oor_zero();
        do_reset();
        set_req(4, 1, 136, 4'hF, 16'hFFFF);
        sample();
        n_chk++; if (req_ready !== 7'b0010000) begin n_fail++; $display("FAIL oor_ready got=%b want=0010000", req_ready); end
        advance();
        idle();
        sample();
        n_chk++; if (err_oor !== 1'b1) begin n_fail++; $display("FAIL oor_pulse got=%b want=1", err_oor); end
        advance();
        for (int k = 0; k < 2; k++) begin
            sample();
            n_chk++; if (err_oor !== 1'b0 || bk_wen !== 4'h0 || bk_cnt[1] !== 3'd0) begin
                n_fail++; $display("FAIL oor_after cyc=%0d got err=%b wen=%b cnt=%0d want 0/0/0", k, err_oor, bk_wen, bk_cnt[1]);
            end
            advance();
        end
        set_req(4, 1, 5, 4'h0, 16'hFFFF);
        sample();
        n_chk++; if (req_ready !== 7'b0010000) begin n_fail++; $display("FAIL zmask_ready got=%b want=0010000", req_ready); end
        advance();
        idle();
        for (int k = 0; k < 3; k++) begin
            sample();
            n_chk++; if (err_oor !== 1'b0 || bk_wen !== 4'h0) begin
                n_fail++; $display("FAIL zmask_nowrite cyc=%0d got err=%b wen=%b want 0/0", k, err_oor, bk_wen);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bk_stall = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 3, 10 + k, 4'hF, 16'hFFFF);
            sample();
            advance();
        end
        req_valid = '0;
        sample();
        n_chk++; if (bk_cnt[3] !== 3'd3) begin n_fail++; $display("FAIL mid_fill got=%0d want=3", bk_cnt[3]); end
        advance();
        rst = 1'b1;
        sample();
        advance();
        rst = 1'b0;
        bk_stall = '0;
        for (int k = 0; k < 4; k++) begin
            sample();
            n_chk++; if (bk_wen !== 4'h0 || bk_cnt !== 12'h0) begin
                n_fail++; $display("FAIL mid_flush cyc=%0d got wen=%b cnt=%h want 0/0", k, bk_wen, bk_cnt);
            end
            advance();
        end
        set_req(0, 3, 20, 4'hF, 16'hFFFF);
        set_req(2, 3, 21, 4'hF, 16'hFFFF);
        sample();
        n_chk++; if (req_ready !== 7'b0000001) begin n_fail++; $display("FAIL mid_rr got=%b want=0000001", req_ready); end
        advance();
        idle();
    endtask

    task automatic test_mask();
        do_reset();
        set_req(5, 0, 3, 4'b0101, 16'hFFFF);
        sample();
        advance();
        idle();
        sample();
        advance();
        sample();
        n_chk++; if (bk_wen[0] !== 1'b1) begin n_fail++; $display("FAIL mask_wen got=%b want=1", bk_wen[0]); end
        n_chk++; if (bk_strb[0] !== 16'h0F0F || bk_tmask[0] !== 4'b0101) begin
            n_fail++; $display("FAIL mask_strb got=%h/%b want=0f0f/0101", bk_strb[0], bk_tmask[0]);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < PU_N; p++) begin
                set_req(p, $urandom_range(0, 3), $urandom_range(0, 140), 4'($urandom), 16'($urandom));
                req_valid[p] = 1'($urandom);
            end
            for (int b = 0; b < BANK_N; b++) bk_stall[b] = ($urandom_range(0, 3) == 0);
            sample();
            n_chk++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready); end
            n_chk++; if (err_oor !== exp_err) begin n_fail++; $display("FAIL rand_err cyc=%0d got=%b want=%b", cyc, err_oor, exp_err); end
            for (int b = 0; b < BANK_N; b++) begin
                n_chk++; if (bk_wen[b] !== exp_wen[b]) begin n_fail++; $display("FAIL rand_wen cyc=%0d bank=%0d got=%b want=%b", cyc, b, bk_wen[b], exp_wen[b]); end
                n_chk++; if (bk_cnt[b] !== 3'(mq[b].size())) begin n_fail++; $display("FAIL rand_cnt cyc=%0d bank=%0d got=%0d want=%0d", cyc, b, bk_cnt[b], mq[b].size()); end
                n_chk++;
                if ({bk_waddr[b], bk_bgrpid[b], bk_tmask[b], bk_strb[b], bk_wdata[b]} !== exp_out[b]) begin
                    n_fail++; $display("FAIL rand_payload cyc=%0d bank=%0d got row=%0d strb=%h want row=%0d strb=%h",
                                       cyc, b, bk_waddr[b], bk_strb[b], exp_out[b].row, exp_out[b].st);
                end
            end
            advance();
        end
        idle();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_waddr  = '0;
        req_bgrpid = '0;
        req_tmask  = '0;
        req_strb   = '0;
        req_wdata  = '0;
        bk_stall   = '0;
        test_reset();
        test_single_write();
        test_contention();
        test_backpressure();
        test_oor_zero();
        test_reset_mid();
        test_mask();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trf_wr_collect.md
TRF_WR_COLLECT -- requirements
Module: trf_wr_collect

Interface
REQ-001 Parameter PU_N, default 7: number of write requesters (functional units).
REQ-002 Parameter BANK_N, default 4: TRF banks; power of two; BW = log2(BANK_N).
REQ-003 Parameter THDB_N, default 4: threads per bank word.
REQ-004 Parameter THD_DW, default 32: bits per thread; SW = THD_DW/8 byte strobes per thread.
REQ-005 Parameter BNK_DPTH, default 136: rows per bank; AW = $clog2(BNK_DPTH).
REQ-006 Parameter FIFO_D, default 4: per-bank write queue depth, >= 2; CW = $clog2(FIFO_D+1).
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 req_valid  in  PU_N  per-requester write request.
REQ-010 req_ready  out  PU_N  per-requester accept; transfer when valid & ready.
REQ-011 req_waddr  in  PU_N x (AW+BW)  low BW bits = bank, upper AW bits = row.
REQ-012 req_bgrpid  in  PU_N x 1  bank-group id, carried through unchanged.
REQ-013 req_tmask  in  PU_N x THDB_N  thread enable.
REQ-014 req_strb  in  PU_N x THDB_N*SW  byte strobes, thread t owns bits [t*SW +: SW].
REQ-015 req_wdata  in  PU_N x THDB_N*THD_DW  write data.
REQ-016 bk_stall  in  BANK_N  bank busy (read port priority); blocks dequeue.
REQ-017 bk_wen  out  BANK_N  one-cycle bank write strobe.
REQ-018 bk_waddr / bk_bgrpid / bk_tmask / bk_strb / bk_wdata  out  BANK_N x (AW / 1 / THDB_N / THDB_N*SW / THDB_N*THD_DW)  bank write payload, valid when bk_wen.
REQ-019 bk_cnt  out  BANK_N x CW  per-bank queue occupancy.
REQ-020 err_oor  out  1  pulse: accepted request had row >= BNK_DPTH.

Function
REQ-021 Bank target of requester p = req_waddr[p][BW-1:0]; each request targets exactly one bank.
REQ-022 Per bank, one grant per cycle, round-robin among requesters with valid and matching bank; pointer starts at 0, moves to (granted index + 1) mod PU_N only on a grant.
REQ-023 Grant to a bank whose queue is not full (bk_cnt < FIFO_D); a same-cycle dequeue never frees space for a same-cycle grant.
REQ-024 req_ready[p] = 1 exactly when p is granted; combinational from current inputs and state; req_ready never depends on another bank's stall.
REQ-025 Accepted request with tmask == 0 or strb masked to all-zero on enabled threads: accepted, not enqueued, no bank write.
REQ-026 Accepted request with row >= BNK_DPTH: not enqueued; err_oor = 1 next cycle for one cycle (OR over all requesters).
REQ-027 Enqueue payload: {row, bgrpid, tmask, strb AND per-thread tmask expansion, wdata} written at end of grant cycle.
REQ-028 Dequeue in cycle T when queue non-empty and bk_stall low in T; head loaded into bk_* registers; bk_wen = 1 in T+1 only.
REQ-029 Minimum latency: accepted in cycle T -> bk_wen in T+2 (empty queue, no stall); one write per bank per cycle sustained.
REQ-030 Per-bank write order = grant order; same-address writes never reordered.
REQ-031 Simultaneous enqueue and dequeue on one bank: bk_cnt unchanged; both take effect.
REQ-032 Queue pointers wrap modulo FIFO_D; bk_cnt ranges 0..FIFO_D.
REQ-033 bk_wen low when not dequeued; bk_* payload holds last value when bk_wen low.

Reset
REQ-034 rst high at a clock edge: queues emptied, bk_cnt = 0, bk_wen = 0, bk_* payload = 0, err_oor = 0, round-robin pointers = 0.
REQ-035 While rst high: req_ready = 0; in-flight queue contents discarded without write (reset mid-operation).
REQ-036 First grant possible in the first cycle with rst low.

Verification
REQ-037 Single write: p=2, waddr=0x01D (bank 1, row 7), tmask=4'hF, rest idle -> req_ready[2] in T, bk_wen[1] in T+2 with bk_waddr[1]=7, data/strobe matched.
REQ-038 Contention: p=0,3,5 all to bank 0 continuously from reset -> grants 0,3,5,0,... one per cycle; bk_wen[0] every cycle from T+2.
REQ-039 Full/backpressure: bk_stall[2]=1, 5 writes to bank 2 -> 4 accepted, bk_cnt[2]=4, 5th held ready=0; release stall -> 5th accepted the cycle after first dequeue, 5 bk_wen in order.
REQ-040 Row out of range: waddr row=136 -> accepted, err_oor pulse at T+1, no bk_wen, bk_cnt unchanged; tmask=0 request -> accepted, no bk_wen, no err_oor.
REQ-041 Reset mid-operation: bank 3 holding 3 entries, assert rst one cycle -> no bk_wen afterward, bk_cnt all 0, next grant to requester 0 first.
REQ-042 Masking: tmask=4'b0101, strb all 1 -> bk_strb = 16'h0F0F.
